// File: rtl/axi4_mem_responder.sv
// AXI4 responder backed by a 512-bit-wide on-chip memory. It has independent
// read and write engines, each with one burst in flight, and counts accepted beats.
module axi4_mem_responder #(
    parameter int DEPTH = 1024,
    parameter int ID_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ID_W-1:0] awid,
    input  logic [63:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic            awvalid,
    output logic            awready,
    input  logic [511:0]    wdata,
    input  logic [63:0]     wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    input  logic [ID_W-1:0] arid,
    input  logic [63:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [511:0]    rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    output logic [31:0]     wr_beat_cnt,
    output logic [31:0]     rd_beat_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    logic [511:0]    r_mem [DEPTH];

    wstate_t         r_wstate;
    wstate_t         w_wstate_next;
    logic            r_awready;
    logic            r_wready;
    logic            r_bvalid;
    logic [ID_W-1:0] r_bid;
    logic [1:0]      r_bresp;
    logic [AW-1:0]   r_widx;
    logic [7:0]      r_wlen;
    logic [8:0]      r_wcnt;

    rstate_t         r_rstate;
    rstate_t         w_rstate_next;
    logic            r_arready;
    logic            r_rvalid;
    logic            r_rlast;
    logic            w_rlast_next;
    logic [ID_W-1:0] r_rid;
    logic [511:0]    r_rdata;
    logic [AW-1:0]   r_ridx;
    logic [7:0]      r_rlen;
    logic [7:0]      r_rbeat;
    logic            w_rd_en;
    logic [AW-1:0]   w_raddr;

    logic [31:0]     r_wr_cnt;
    logic [31:0]     r_rd_cnt;

    logic            w_aw_hs;
    logic            w_w_hs;
    logic            w_b_hs;
    logic            w_ar_hs;
    logic            w_r_hs;
    logic            w_mem_we;
    logic            w_unused;

    assign w_aw_hs = awvalid & r_awready;
    assign w_w_hs  = wvalid & r_wready;
    assign w_b_hs  = r_bvalid & bready;
    assign w_ar_hs = arvalid & r_arready;
    assign w_r_hs  = r_rvalid & rready;

    // Beats past len+1 are acknowledged but dropped; a beat caught by reset is dropped too.
    assign w_mem_we = w_w_hs && (r_wcnt <= {1'b0, r_wlen}) && !rst;

    assign w_unused = ^{awsize, arsize, awaddr[63:AW+6], awaddr[5:0],
                        araddr[63:AW+6], araddr[5:0]};

    // ---------------- write engine ----------------
    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_next = W_DATA;
            W_DATA:  if (w_w_hs && wlast) w_wstate_next = W_RESP;
            W_RESP:  if (w_b_hs) w_wstate_next = W_IDLE;
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_next;
            r_awready <= (w_wstate_next == W_IDLE);
            r_wready  <= (w_wstate_next == W_DATA);
            r_bvalid  <= (w_wstate_next == W_RESP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bid   <= '0;
            r_bresp <= 2'b00;
            r_widx  <= '0;
            r_wlen  <= '0;
            r_wcnt  <= '0;
        end else begin
            if (w_aw_hs) begin
                r_bid  <= awid;
                r_widx <= awaddr[6 +: AW];
                r_wlen <= awlen;
                r_wcnt <= '0;
            end
            if (w_w_hs) begin
                r_widx <= r_widx + IDX_ONE;
                if (r_wcnt != 9'h1FF)
                    r_wcnt <= r_wcnt + 9'd1;
                if (wlast)
                    r_bresp <= (r_wcnt == {1'b0, r_wlen}) ? 2'b00 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 64; b++) begin
                if (wstrb[b])
                    r_mem[r_widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    always_comb begin
        w_rstate_next = r_rstate;
        w_rlast_next  = r_rlast;
        w_rd_en       = 1'b0;
        w_raddr       = r_ridx;
        case (r_rstate)
            R_IDLE: if (w_ar_hs) w_rstate_next = R_FETCH;
            R_FETCH: begin
                w_rstate_next = R_DATA;
                w_rd_en       = 1'b1;
                w_rlast_next  = (r_rlen == 8'd0);
            end
            R_DATA: begin
                if (w_r_hs) begin
                    if (r_rlast) begin
                        w_rstate_next = R_IDLE;
                        w_rlast_next  = 1'b0;
                    end else begin
                        // Fetch the next word as the current one is taken: no bubbles.
                        w_rd_en      = 1'b1;
                        w_raddr      = r_ridx + IDX_ONE;
                        w_rlast_next = ((r_rbeat + 8'd1) == r_rlen);
                    end
                end
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_next;
            r_arready <= (w_rstate_next == R_IDLE);
            r_rvalid  <= (w_rstate_next == R_DATA);
            r_rlast   <= w_rlast_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rid   <= '0;
            r_ridx  <= '0;
            r_rlen  <= '0;
            r_rbeat <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rid   <= arid;
                r_ridx  <= araddr[6 +: AW];
                r_rlen  <= arlen;
                r_rbeat <= '0;
            end
            if (r_rstate == R_DATA && w_r_hs && !r_rlast) begin
                r_ridx  <= r_ridx + IDX_ONE;
                r_rbeat <= r_rbeat + 8'd1;
            end
        end
    end

    // Registered read port; it sees the pre-write word on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (rst)
            r_rdata <= '0;
        else if (w_rd_en)
            r_rdata <= r_mem[w_raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_w_hs) r_wr_cnt <= r_wr_cnt + 32'd1;
            if (w_r_hs) r_rd_cnt <= r_rd_cnt + 32'd1;
        end
    end

    assign awready     = r_awready;
    assign wready      = r_wready;
    assign bvalid      = r_bvalid;
    assign bid         = r_bid;
    assign bresp       = r_bresp;
    assign arready     = r_arready;
    assign rvalid      = r_rvalid;
    assign rlast       = r_rlast;
    assign rid         = r_rid;
    assign rdata       = r_rdata;
    assign rresp       = 2'b00;
    assign wr_beat_cnt = r_wr_cnt;
    assign rd_beat_cnt = r_rd_cnt;

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: a table of single-beat write/read pairs
// followed by hand-written burst, wrap, error, concurrency and reset sequences.
module tb_axi4_mem_responder;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   awid, arid, bid, rid;
    logic [63:0]   awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [511:0]  wdata, rdata;
    logic [63:0]   wstrb;
    logic [1:0]    bresp, rresp;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [31:0]   wr_beat_cnt, rd_beat_cnt;

    always #5 clk = ~clk;

    axi4_mem_responder #(.DEPTH(1024), .ID_W(16)) dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .wr_beat_cnt(wr_beat_cnt), .rd_beat_cnt(rd_beat_cnt)
    );

    typedef struct {
        logic [15:0]  awid;
        logic [63:0]  waddr;
        logic [511:0] wdata;
        logic [63:0]  wstrb;
        logic [15:0]  arid;
        logic [63:0]  raddr;
        logic [511:0] exp;
    } vec_t;

    int           n_checks = 0;
    int           n_pass = 0;
    int           exp_wr = 0;
    int           exp_rd = 0;
    logic [511:0] wbuf [256];
    logic [511:0] rbuf [256];
    vec_t         vecs [6];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic do_write(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input int nbeats, input logic [63:0] strb, output logic [1:0] resp);
        int t;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd6; awvalid = 1'b1;
        // Beat 0 is offered alongside AW; it must not be taken until W_DATA.
        wdata = wbuf[0]; wstrb = strb; wlast = (nbeats == 1); wvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        check("aw_wait", t < 50, 1);
        @(negedge clk);
        awvalid = 1'b0;
        check("aw_then_wready", {awready, wready}, 2'b01);
        for (int i = 0; i < nbeats; i++) begin
            wdata = wbuf[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
            check("wready_beat", wready, 1);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        exp_wr += nbeats;
        check("bvalid_after_last", {bvalid, wready}, 2'b10);
        check("bid", bid, id);
        resp = bresp;
        repeat (2) @(negedge clk);
        check("b_hold", {bvalid, bid}, {1'b1, id});
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("b_done_awready", {bvalid, awready}, 2'b01);
        check("wr_beat_cnt", wr_beat_cnt, exp_wr);
        $display("WR id=%h addr=%h len=%0d beats=%0d bresp=%0d", id, addr, len, nbeats, resp);
    endtask

    task automatic do_read(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input bit bp);
        int t, n;
        bit held;
        logic [511:0] hd;
        logic hl;
        arid = id; araddr = addr; arlen = len; arsize = 3'd6; arvalid = 1'b1; rready = 1'b0;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        check("ar_wait", t < 50, 1);
        @(negedge clk);
        arvalid = 1'b0;
        check("r_fetch_cycle", {rvalid, arready}, 2'b00);
        @(negedge clk);
        check("r_first_at_n2", rvalid, 1);
        n = 0; t = 0; held = 0;
        while (n <= int'(len) && t < 2000) begin
            if (held) begin
                check("r_hold_valid", rvalid, 1);
                check("r_hold_data", rdata, hd);
                check("r_hold_last", rlast, hl);
            end
            rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rvalid) begin
                if (rready) begin
                    rbuf[n] = rdata;
                    check("rlast", rlast, n == int'(len));
                    check("rid", rid, id);
                    check("rresp", rresp, 2'b00);
                    n++;
                    held = 0;
                end else begin
                    held = 1; hd = rdata; hl = rlast;
                end
            end else begin
                held = 0;
                if (!bp) check("r_no_bubble", rvalid, 1);
            end
            @(negedge clk);
            t++;
        end
        rready = 1'b0;
        check("r_beats_done", n, int'(len) + 1);
        check("r_done_arready", {rvalid, arready}, 2'b01);
        exp_rd += int'(len) + 1;
        check("rd_beat_cnt", rd_beat_cnt, exp_rd);
        $display("RD id=%h addr=%h len=%0d beats=%0d stall=%0d", id, addr, len, n, bp);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]   resp;
        logic [511:0] pat_a, pat_b, pat_c, ones, mark;
        int n, t;

        pat_a = {8{64'hA5A5_0001_DEAD_BEEF}};
        pat_b = {8{64'hCAFE_F00D_1234_5678}};
        pat_c = {8{64'h0123_4567_89AB_CDEF}};
        ones  = '1;
        mark  = {16{32'h5EED_0202}};

        vecs[0] = '{16'h0012, 64'h40,    pat_a, '1, 16'h0034, 64'h40, pat_a};
        vecs[1] = '{16'h0001, 64'h80,    ones,  '1, 16'h0002, 64'h80, ones};
        vecs[2] = '{16'h0003, 64'h80,    '0, 64'hFF, 16'h0004, 64'h80, {{448{1'b1}}, 64'h0}};
        vecs[3] = '{16'h0005, 64'h80,    pat_c, 64'hFF00_0000_0000_0000, 16'h0006, 64'h80,
                    {64'h0123_4567_89AB_CDEF, {384{1'b1}}, 64'h0}};
        vecs[4] = '{16'hFFFF, 64'h100C0, pat_b, '1, 16'hBEEF, 64'hFF, pat_b};
        vecs[5] = '{16'h0007, 64'h40,    '0, 64'h0, 16'h0008, 64'h7F, pat_a};

        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctl", {awready, wready, bvalid, arready, rvalid, rlast}, 6'b0);
        check("rst_resp", {bresp, rresp}, 4'b0);
        check("rst_ids", {bid, rid}, 32'b0);
        check("rst_rdata", rdata, '0);
        check("rst_cnt", {wr_beat_cnt, rd_beat_cnt}, 64'b0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {awready, arready}, 2'b11);

        for (int v = 0; v < 6; v++) begin
            wbuf[0] = vecs[v].wdata;
            do_write(vecs[v].awid, vecs[v].waddr, 8'd0, 1, vecs[v].wstrb, resp);
            check("tbl_bresp", resp, 2'b00);
            do_read(vecs[v].arid, vecs[v].raddr, 8'd0, 1'b0);
            check("tbl_rdata", rbuf[0], vecs[v].exp);
        end

        // 256-beat burst, random read backpressure
        for (int i = 0; i < 256; i++) wbuf[i] = 512'(i);
        do_write(16'h0101, 64'h4000, 8'd255, 256, '1, resp);
        check("burst_bresp", resp, 2'b00);
        do_read(16'h0202, 64'h4000, 8'd255, 1'b1);
        for (int i = 0; i < 256; i++) check("burst_data", rbuf[i], 512'(i));

        // Wrap from word 1022 through 0, then alias at 0x10000
        for (int i = 0; i < 4; i++) wbuf[i] = 512'(100 + i);
        do_write(16'h0303, 64'hFF80, 8'd3, 4, '1, resp);
        check("wrap_bresp", resp, 2'b00);
        do_read(16'h0404, 64'hFF80, 8'd3, 1'b0);
        for (int i = 0; i < 4; i++) check("wrap_data", rbuf[i], 512'(100 + i));
        do_read(16'h0505, 64'h10000, 8'd0, 1'b0);
        check("alias_word0", rbuf[0], 512'(102));
        do_read(16'h0606, 64'h40, 8'd0, 1'b0);
        check("wrap_word1", rbuf[0], 512'(103));

        // Early wlast -> SLVERR
        wbuf[0] = 512'(1); wbuf[1] = 512'(2);
        do_write(16'h0707, 64'h8000, 8'd3, 2, '1, resp);
        check("short_bresp", resp, 2'b10);

        // Overlong burst: extra beats acknowledged, not written, SLVERR
        wbuf[0] = mark;
        do_write(16'h0808, 64'h8080, 8'd0, 1, '1, resp);
        for (int i = 0; i < 3; i++) wbuf[i] = 512'(200 + i);
        do_write(16'h0909, 64'h8040, 8'd0, 3, '1, resp);
        check("long_bresp", resp, 2'b10);
        do_read(16'h0A0A, 64'h8040, 8'd0, 1'b0);
        check("long_first", rbuf[0], 512'(200));
        do_read(16'h0A0B, 64'h8080, 8'd0, 1'b0);
        check("long_not_written", rbuf[0], mark);

        // Simultaneous 8-beat read and write over the same words
        for (int i = 0; i < 8; i++) wbuf[i] = 512'(300 + i);
        do_write(16'h0B0B, 64'hC000, 8'd7, 8, '1, resp);
        for (int i = 0; i < 8; i++) wbuf[i] = 512'(900 + i);
        fork
            do_write(16'h0C0C, 64'hC000, 8'd7, 8, '1, resp);
            do_read(16'h0D0D, 64'hC000, 8'd7, 1'b0);
        join
        check("conc_bresp", resp, 2'b00);
        for (int i = 0; i < 8; i++) check("conc_old_data", rbuf[i], 512'(300 + i));
        do_read(16'h0E0E, 64'hC000, 8'd7, 1'b1);
        for (int i = 0; i < 8; i++) check("conc_new_data", rbuf[i], 512'(900 + i));

        // Reset after 3 of 8 read beats
        arid = 16'h0F0F; araddr = 64'hC000; arlen = 8'd7; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        n = 0; t = 0;
        while (n < 3 && t < 50) begin
            if (rvalid) n++;
            @(negedge clk);
            t++;
        end
        check("rst_mid_beats", n, 3);
        rready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_rvalid", rvalid, 0);
        check("rst_mid_cnt", {wr_beat_cnt, rd_beat_cnt}, 64'b0);
        @(negedge clk);
        check("rst_mid_arready", {arready, awready}, 2'b11);
        rready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("rst_no_beats", rvalid, 0);
            @(negedge clk);
        end
        rready = 1'b0;
        check("rst_cnt_idle", rd_beat_cnt, 0);
        $display("RST mid-burst after %0d beats", n);
        exp_wr = 0;
        exp_rd = 0;
        do_read(16'h1010, 64'hC000, 8'd7, 1'b0);
        for (int i = 0; i < 8; i++) check("rst_mem_kept", rbuf[i], 512'(900 + i));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi4_mem_responder.md
# axi4_mem_responder

AXI4 slave (responder) that terminates one DRAM-facing AXI4 port with an on-chip 512-bit-wide memory model and serves the INCR bursts issued by `mem_ctrl` through `dram_interconnect`. It stands in for a DDR channel in simulation and in bring-up builds, and counts accepted data beats for throughput checks. Read and write channels are independent, each with one outstanding burst.

## Interface
- `DEPTH`, 1024: memory size in 512-bit words; power of two, at least 2.
- `ID_W`, 16: AXI ID width.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `awid`/`awaddr`/`awlen`/`awsize`/`awvalid`  in  ID_W/64/8/3/1  write address channel.
- `awready`  out  1.
- `wdata`/`wstrb`/`wlast`/`wvalid`  in  512/64/1/1  write data channel.
- `wready`  out  1.
- `bid`/`bresp`/`bvalid`  out  ID_W/2/1.
- `bready`  in  1.
- `arid`/`araddr`/`arlen`/`arsize`/`arvalid`  in  ID_W/64/8/3/1  read address channel.
- `arready`  out  1.
- `rid`/`rdata`/`rresp`/`rlast`/`rvalid`  out  ID_W/512/2/1/1.
- `rready`  in  1.
- `wr_beat_cnt`, `rd_beat_cnt`  out  32  accepted W beats and R beats, wrapping.

## Operation
- Word index = `addr[6 +: log2(DEPTH)]`. Upper address bits are ignored, so addresses alias modulo DEPTH×64 B. `addr[5:0]` is ignored.
- Every burst is treated as INCR with 64 B beats. `awsize`/`arsize` are ignored. Burst length = len+1 (1..256 beats).
- The word index increments per beat and wraps from DEPTH-1 to 0.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: `awready`=1. An AW handshake latches id, index and len, then goes to W_DATA.
  - W_DATA: `wready`=1. Each W handshake writes the bytes enabled by `wstrb`, increments the index and increments the beat count.
  - The burst ends on the beat with `wlast`=1, then goes to W_RESP.
  - `bresp`=2'b00 if the beat count equals len+1, otherwise 2'b10 (SLVERR).
  - Beats beyond len+1 that arrive before `wlast` are accepted but not written.
  - W_RESP: `bvalid`=1 and `bid`=latched id, both held until `bready`.
- Read FSM: R_IDLE -> R_FETCH -> R_DATA -> R_IDLE.
  - R_IDLE: `arready`=1. An AR handshake latches id, index and len.
  - R_FETCH: one cycle of synchronous memory read.
  - R_DATA: `rvalid`=1, `rid`=latched id, `rresp`=2'b00, `rlast`=1 on beat len.
  - A prefetch or skid buffer sustains one beat per cycle while `rready`=1.
  - While `rvalid`=1 and `rready`=0, `rdata`/`rlast`/`rid` hold stable.
- Same-word read and write in the same cycle: the read returns the old data (read-first).
- Counters increment on each W and R handshake respectively, and wrap 0xFFFF_FFFF -> 0.
- Reset:
  - Returns both FSMs to IDLE and zeroes the counters.
  - Memory contents are not cleared.
  - A reset during a burst abandons it: no B or R response is issued for that burst.

## Timing
- Reset values: `awready`=0, `wready`=0, `bvalid`=0, `arready`=0, `rvalid`=0, `rlast`=0, `bresp`=0, `rresp`=0, `bid`=0, `rid`=0, `rdata`=0, counters=0.
- `awready` and `arready` rise in the first cycle after `rst` deasserts.
- All outputs are registered.
- Write path:
  - AW handshake at cycle N: `awready`=0 and `wready`=1 from N+1.
  - Final W beat at M: `wready`=0 and `bvalid`=1 from M+1.
  - B handshake at K: `bvalid`=0 and `awready`=1 from K+1.
- Read path:
  - AR handshake at N: first `rvalid` at N+2.
  - With `rready` held high, beat i is presented at N+2+i; an L-beat burst spans N+2 .. N+1+L with no bubbles.
  - Last R handshake at K: `rvalid`=0 and `arready`=1 from K+1.
- A W beat presented in the same cycle as the AW handshake is not accepted (`wready`=0 in W_IDLE).
- Minimum write latency from AW handshake to `bvalid` is 2 cycles, for a single beat.

## Test plan
- Single beat:
  - Stimulus: write awaddr=0x40, awlen=0, awid=0x12, wdata=pattern A, wstrb all-ones. Then read araddr=0x40, arlen=0, arid=0x34.
  - Required: bid=0x12, bresp=0. rid=0x34, rdata=A, rlast=1, first rvalid exactly 2 cycles after the AR handshake. Counters read 1/1.
- Full burst with backpressure:
  - Stimulus: 256-beat write (awlen=255), beat i = i. 256-beat read with `rready` toggled pseudo-randomly.
  - Required: every beat returns i in order with data held stable during stalls; rlast only on beat 255; rd_beat_cnt=256.
- Wrap and alias (DEPTH=1024):
  - Stimulus: 4-beat write at word 1022.
  - Required: the data lands at words 1022, 1023, 0, 1. A read at byte address 0x10000 (word 0, aliased) returns beat 2.
- Byte strobes and error response:
  - Stimulus: write with wstrb=0x0000_0000_0000_00FF over an all-ones word, then a read of that word.
  - Required: only bytes 0-7 change.
  - Stimulus: awlen=3 with `wlast` on beat 1.
  - Required: bresp=2'b10.
- Concurrency:
  - Stimulus: simultaneous 8-beat read and 8-beat write to the same addresses.
  - Required: the read returns pre-write data for every beat issued in the same cycle as or before the corresponding write; both channels complete independently.
- Reset mid-burst:
  - Stimulus: assert `rst` for 1 cycle after 3 of 8 read beats.
  - Required: `rvalid`=0 the next cycle, no further beats, `arready`=1 one cycle after `rst` deasserts, counters=0, memory unchanged.
